// File: rtl/axis_fan_in_if.sv
// axis_fan_in_if: bundles the NUM_FANIN slave streams and the single master
// stream of the fan-in arbiter.
//   master : view taken by the fan-in block (drives m_axis_* and s_axis_tready)
//   slave  : view taken by the environment (drives s_axis_* and m_axis_tready)
interface axis_fan_in_if #(
    parameter int NUM_FANIN  = 6,
    parameter int DATA_WIDTH = 256
);
    logic [NUM_FANIN-1:0]            s_axis_tvalid;
    logic [NUM_FANIN-1:0]            s_axis_tready;
    logic [NUM_FANIN*DATA_WIDTH-1:0] s_axis_tdata;
    logic [NUM_FANIN-1:0]            s_axis_tlast;
    logic                            m_axis_tvalid;
    logic                            m_axis_tready;
    logic [DATA_WIDTH-1:0]           m_axis_tdata;
    logic [NUM_FANIN-1:0]            m_axis_tuser;
    logic                            m_axis_tlast;

    modport master (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast
    );

    modport slave (
        output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast
    );
endinterface

// File: rtl/axis_fan_in.sv
// axis_fan_in: N-to-1 AXI-stream fan-in with packet-locked arbitration.
// A channel is granted in IDLE and keeps the output until its tlast beat is
// accepted. m_axis_tuser carries the one-hot source channel of each beat.
// Build option AXIS_FAN_IN_FIXED_PRIO_EN: when defined, arbitration is fixed
// priority (lowest index wins) and the round-robin pointer disappears;
// otherwise arbitration is round-robin starting after the last served channel.
module axis_fan_in #(
    parameter int NUM_FANIN  = 6,
    parameter int DATA_WIDTH = 256
) (
    input  logic           clk,
    input  logic           rst,
    axis_fan_in_if.master  axis
);
    localparam int IW = (NUM_FANIN > 1) ? $clog2(NUM_FANIN) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         grant_q, grant_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [NUM_FANIN-1:0]  m_user_q, m_user_d;
    logic                  m_last_q, m_last_d;
`ifndef AXIS_FAN_IN_FIXED_PRIO_EN
    logic [IW-1:0]         ptr_q, ptr_d;
`endif

    logic [DATA_WIDTH-1:0] data_arr [NUM_FANIN];
    logic [NUM_FANIN-1:0]  s_ready;
    logic [IW-1:0]         arb_idx;
    logic                  ld;
    logic                  beat;

    // Unpack the flat tdata bus into one word per channel.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_FANIN; gi++) begin : g_ch
            assign data_arr[gi] = axis.s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // The output register can take a new beat when empty or being drained.
    assign ld   = ~m_valid_q | axis.m_axis_tready;
    assign beat = (state_q == LOCKED) & axis.s_axis_tvalid[grant_q] & ld;

    // Only the granted channel sees tready, and only while the output can load.
    always_comb begin
        s_ready = '0;
        if (state_q == LOCKED) begin
            s_ready[grant_q] = ld;
        end
    end

    // Arbitration: pick the winner among the currently valid channels.
    always_comb begin
        arb_idx = '0;
`ifdef AXIS_FAN_IN_FIXED_PRIO_EN
        for (int i = NUM_FANIN - 1; i >= 0; i--) begin
            if (axis.s_axis_tvalid[i]) begin
                arb_idx = IW'(i);
            end
        end
`else
        // Walk offsets from far to near so the channel closest after ptr wins.
        for (int off = NUM_FANIN; off >= 1; off--) begin
            if (axis.s_axis_tvalid[(int'(ptr_q) + off) % NUM_FANIN]) begin
                arb_idx = IW'((int'(ptr_q) + off) % NUM_FANIN);
            end
        end
`endif
    end

    // Next-state: FSM, grant, pointer and output register.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_user_d  = m_user_q;
        m_last_d  = m_last_q;
`ifndef AXIS_FAN_IN_FIXED_PRIO_EN
        ptr_d     = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (|axis.s_axis_tvalid) begin
                    grant_d = arb_idx;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (beat && axis.s_axis_tlast[grant_q]) begin
`ifndef AXIS_FAN_IN_FIXED_PRIO_EN
                    ptr_d   = grant_q;
`endif
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (beat) begin
            m_valid_d = 1'b1;
            m_data_d  = data_arr[grant_q];
            m_last_d  = axis.s_axis_tlast[grant_q];
            m_user_d  = {{(NUM_FANIN-1){1'b0}}, 1'b1} << grant_q;
        end else if (ld) begin
            m_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_user_q  <= '0;
            m_last_q  <= 1'b0;
`ifndef AXIS_FAN_IN_FIXED_PRIO_EN
            ptr_q     <= IW'(NUM_FANIN - 1);
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_user_q  <= m_user_d;
            m_last_q  <= m_last_d;
`ifndef AXIS_FAN_IN_FIXED_PRIO_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign axis.s_axis_tready = s_ready;
    assign axis.m_axis_tvalid = m_valid_q;
    assign axis.m_axis_tdata  = m_data_q;
    assign axis.m_axis_tuser  = m_user_q;
    assign axis.m_axis_tlast  = m_last_q;

endmodule

// File: tb/tb_axis_fan_in.sv
// tb_axis_fan_in: scoreboard bench for axis_fan_in. Source beats are pushed
// to a per-channel expected queue when accepted on s_axis and popped when the
// matching beat leaves m_axis. Directed scenarios check latency, ordering,
// stall stability, packet locking and reset; a random phase stresses all lanes.
module tb_axis_fan_in;
    localparam int N  = 6;
    localparam int DW = 256;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            gap;
    } beat_t;

    logic clk;
    logic rst;

    axis_fan_in_if #(.NUM_FANIN(N), .DATA_WIDTH(DW)) bus ();

    axis_fan_in #(.NUM_FANIN(N), .DATA_WIDTH(DW)) dut (
        .clk  (clk),
        .rst  (rst),
        .axis (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    int            cyc = 0;
    beat_t         src_q [N][$];
    logic [DW:0]   exp_q [N][$];
    int            gap_left [N];
    int            vprob [N];
    int            s_beats [N];
    int            last_acc [N];
    int            rprob = 100;
    bit            rdy_pat [$];
    int            pkt_log [$];
    logic [N-1:0]  s_acc = '0;
    bit            in_pkt = 0;
    int            cur_ch = 0;
    int            beat_cnt = 0;
    int            first_mv_cyc = -1;
    int            n_stall = 0;
    logic [N-1:0]  last_user = '0;
    bit            held_v = 0;
    logic [299:0]  held_val = '0;

    task automatic chk(input string tag, input logic [299:0] obs, input logic [299:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_beat(input int ch, input logic [DW-1:0] d, input logic last, input int gap);
        beat_t b;
        b.data = d;
        b.last = last;
        b.gap  = gap;
        if (src_q[ch].size() == 0) gap_left[ch] = gap;
        src_q[ch].push_back(b);
    endtask

    task automatic push_pkt(input int ch, input int len, input int max_gap);
        logic [DW-1:0] d;
        for (int b = 0; b < len; b++) begin
            for (int w = 0; w < DW/32; w++) d[w*32 +: 32] = $urandom;
            d[DW-1 -: 8] = 8'(ch);
            push_beat(ch, d, (b == len - 1), (max_gap == 0) ? 0 : int'($urandom_range(max_gap)));
        end
    endtask

    function automatic bit busy();
        bit r = bus.m_axis_tvalid;
        for (int c = 0; c < N; c++)
            if (src_q[c].size() != 0 || exp_q[c].size() != 0) r = 1;
        return r;
    endfunction

    // Record a beat accepted on the slave side into the scoreboard.
    task automatic apply_acc();
        beat_t b;
        for (int c = 0; c < N; c++) begin
            if (s_acc[c] && !rst && src_q[c].size() != 0) begin
                b = src_q[c].pop_front();
                exp_q[c].push_back({b.last, b.data});
                s_beats[c]++;
                if (b.last) last_acc[c]++;
                if (src_q[c].size() != 0) gap_left[c] = src_q[c][0].gap;
            end
        end
    endtask

    // Present source beats (holding any unaccepted beat) and master ready.
    task automatic drive();
        for (int c = 0; c < N; c++) begin
            if (bus.s_axis_tvalid[c] && !s_acc[c]) continue;
            bus.s_axis_tvalid[c] = 1'b0;
            if (src_q[c].size() != 0) begin
                if (gap_left[c] > 0) begin
                    gap_left[c]--;
                end else if (int'($urandom_range(99)) < vprob[c]) begin
                    bus.s_axis_tvalid[c]           = 1'b1;
                    bus.s_axis_tdata[c*DW +: DW]   = src_q[c][0].data;
                    bus.s_axis_tlast[c]            = src_q[c][0].last;
                end
            end
        end
        s_acc = '0;
        if (rdy_pat.size() != 0) bus.m_axis_tready = rdy_pat.pop_front();
        else bus.m_axis_tready = (int'($urandom_range(99)) < rprob);
    endtask

    // A beat leaving m_axis: compare against the source scoreboard.
    task automatic beat_out();
        int ch = -1;
        for (int i = 0; i < N; i++) if (bus.m_axis_tuser[i]) ch = i;
        chk("tuser_onehot", $onehot(bus.m_axis_tuser), 1);
        if (ch < 0) ch = 0;
        last_user = bus.m_axis_tuser;
        if (in_pkt) chk("interleave", ch, cur_ch);
        else pkt_log.push_back(ch);
        chk("sb_avail", exp_q[ch].size() != 0, 1);
        if (exp_q[ch].size() != 0)
            chk($sformatf("beat_ch%0d", ch), {bus.m_axis_tlast, bus.m_axis_tdata}, exp_q[ch].pop_front());
        beat_cnt++;
        in_pkt = !bus.m_axis_tlast;
        cur_ch = ch;
        if (bus.m_axis_tlast) $display("pkt %0d: ch=%0d beats=%0d cyc=%0d", pkt_log.size(), ch, beat_cnt, cyc);
        if (bus.m_axis_tlast) beat_cnt = 0;
    endtask

    task automatic observe();
        logic [299:0] cur;
        if (rst) begin
            s_acc  = '0;
            held_v = 0;
            return;
        end
        cur = {bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tuser, bus.m_axis_tdata};
        s_acc = bus.s_axis_tvalid & bus.s_axis_tready;
        if (held_v) chk("stall_hold", cur, held_val);
        if (bus.m_axis_tvalid && !bus.m_axis_tready) begin
            chk("stall_tready", bus.s_axis_tready, 0);
            n_stall++;
        end
        held_v   = bus.m_axis_tvalid && !bus.m_axis_tready;
        held_val = cur;
        if (bus.m_axis_tvalid && first_mv_cyc < 0) first_mv_cyc = cyc;
        if (bus.m_axis_tvalid && bus.m_axis_tready) beat_out();
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        apply_acc();
        drive();
        @(negedge clk);
        observe();
    endtask

    task automatic flush();
        for (int c = 0; c < N; c++) begin
            src_q[c].delete();
            exp_q[c].delete();
            gap_left[c] = 0;
        end
        bus.s_axis_tvalid = '0;
        s_acc  = '0;
        in_pkt = 0;
        held_v = 0;
        beat_cnt = 0;
        pkt_log.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        flush();
    endtask

    task automatic drain(input string tag, input int limit);
        int k = 0;
        while (busy() && k < limit) begin
            step();
            k++;
        end
        chk(tag, busy(), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int start, base, k;
        int exp_order [4];
        rst = 1'b1;
        bus.s_axis_tvalid = '0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tlast  = '0;
        bus.m_axis_tready = 1'b0;
        for (int c = 0; c < N; c++) begin
            vprob[c] = 100;
            gap_left[c] = 0;
            s_beats[c] = 0;
            last_acc[c] = 0;
        end

        // Reset state
        step(); step(); step();
        chk("rst_mvalid", bus.m_axis_tvalid, 0);
        chk("rst_mdata",  bus.m_axis_tdata, 0);
        chk("rst_muser",  bus.m_axis_tuser, 0);
        chk("rst_mlast",  bus.m_axis_tlast, 0);
        chk("rst_sready", bus.s_axis_tready, 0);
        rst = 1'b0;
        flush();

        // Channel 2, 3-beat packet: latency, tuser, data
        push_beat(2, DW'(8'hA1), 1'b0, 0);
        push_beat(2, DW'(8'hA2), 1'b0, 0);
        push_beat(2, DW'(8'hA3), 1'b1, 0);
        start = cyc + 1;
        first_mv_cyc = -1;
        drain("t1_drain", 200);
        chk("t1_latency", first_mv_cyc - start, 2);
        chk("t1_tuser", last_user, 6'b000100);
        chk("t1_npkt", pkt_log.size(), 1);
        if (pkt_log.size() > 0) chk("t1_src", pkt_log[0], 2);

        // Channels 0,1,5 pending together; channel 0 refills immediately
        do_reset();
        push_pkt(0, 2, 0);
        push_pkt(0, 2, 0);
        push_pkt(1, 2, 0);
        push_pkt(5, 2, 0);
`ifdef AXIS_FAN_IN_FIXED_PRIO_EN
        exp_order = '{0, 0, 1, 5};
`else
        exp_order = '{0, 1, 5, 0};
`endif
        drain("t2_drain", 200);
        chk("t2_npkt", pkt_log.size(), 4);
        for (int i = 0; i < 4 && i < pkt_log.size(); i++)
            chk($sformatf("t2_order%0d", i), pkt_log[i], exp_order[i]);

        // Channel 3 with output back-pressure 1,0,0,1 mid-packet
        pkt_log.delete();
        n_stall = 0;
        push_pkt(3, 3, 0);
        rdy_pat = '{1, 1, 1, 0, 0, 1};
        drain("t3_drain", 200);
        chk("t3_stalls", n_stall, 2);
        chk("t3_npkt", pkt_log.size(), 1);

        // Channel 4 gaps mid-packet, channel 0 must wait for its tlast
        do_reset();
        push_pkt(4, 4, 0);
        src_q[4][2].gap = 3;
        step();
        push_pkt(0, 1, 0);
        base = last_acc[4];
        k = 0;
        while (last_acc[4] == base && k < 100) begin
            step();
            chk("t4_blocked0", bus.s_axis_tready[0], 0);
            k++;
        end
        drain("t4_drain", 200);
        chk("t4_npkt", pkt_log.size(), 2);
        if (pkt_log.size() == 2) begin
            chk("t4_first", pkt_log[0], 4);
            chk("t4_second", pkt_log[1], 0);
        end

        // Reset on the 2nd beat of a 4-beat packet
        do_reset();
        push_pkt(3, 4, 0);
        base = s_beats[3];
        k = 0;
        while (s_beats[3] == base && k < 50) begin
            step();
            k++;
        end
        rst = 1'b1;
        step();
        chk("t5_mvalid", bus.m_axis_tvalid, 0);
        chk("t5_muser",  bus.m_axis_tuser, 0);
        chk("t5_mlast",  bus.m_axis_tlast, 0);
        chk("t5_sready", bus.s_axis_tready, 0);
        rst = 1'b0;
        flush();
        push_pkt(3, 1, 0);
        push_pkt(0, 1, 0);
        drain("t5_drain", 200);
        chk("t5_npkt", pkt_log.size(), 2);
        if (pkt_log.size() == 2) begin
            chk("t5_tie_first", pkt_log[0], 0);
            chk("t5_tie_second", pkt_log[1], 3);
        end

        // Random stress: 1000 packets over all channels
        do_reset();
        for (int c = 0; c < N; c++) vprob[c] = 50 + int'($urandom_range(50));
        rprob = 70;
        for (int p = 0; p < 1000; p++)
            push_pkt(int'($urandom_range(N - 1)), 1 + int'($urandom_range(3)), 2);
        drain("t6_drain", 60000);
        chk("t6_npkt", pkt_log.size(), 1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
